// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare and W1C pending.
// Define MMIO_TIMER_AUTO_RELOAD_EN to add CTRL.reload_en (wrap mtime to 0 on match).
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_4000,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        timer_interrupt
);

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic [31:0]        shadow;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;
    logic               en;
    logic               irq_en;
    logic               reload_en;
    logic               pending;

    logic        sel;
    logic [2:0]  off;
    logic [1:0]  lane;
    logic        size_ok;
    logic [3:0]  be_base;
    logic [3:0]  wstb;
    logic [31:0] wd;
    logic [31:0] word;
    logic [31:0] shifted;
    logic        match;
    logic        tick;
    logic        wrap;
    logic        wr_time;

    assign sel  = (addr[31:5] == BASE_ADDR[31:5]);
    assign off  = addr[4:2];
    assign lane = addr[1:0];

    always_comb begin
        be_base = 4'b0000;
        size_ok = 1'b0;
        case (mem_acc_mode)
            3'b000, 3'b100: begin
                be_base = 4'b0001;
                size_ok = 1'b1;
            end
            3'b001, 3'b101: begin
                be_base = 4'b0011;
                size_ok = ~addr[0];
            end
            3'b010: begin
                be_base = 4'b1111;
                size_ok = (addr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    assign wstb = (wr_en && sel && size_ok) ? (be_base << lane) : 4'b0000;
    assign wd   = wdata << {lane, 3'b000};

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [3:0]  stb,
                                          input logic [31:0] data);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = stb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        word = 32'b0;
        case (off)
            3'd0:    word = mtime[31:0];
            3'd1:    word = shadow;
            3'd2:    word = mtimecmp[31:0];
            3'd3:    word = mtimecmp[63:32];
            3'd4:    word = {29'b0, reload_en, irq_en, en};
            3'd5:    word = 32'(prescale);
            3'd6:    word = {31'b0, pending};
            default: word = 32'b0;
        endcase
    end

    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        rdata = 32'b0;
        if (rd_en && sel && size_ok) begin
            case (mem_acc_mode)
                3'b000:  rdata = {{24{shifted[7]}}, shifted[7:0]};
                3'b100:  rdata = {24'b0, shifted[7:0]};
                3'b001:  rdata = {{16{shifted[15]}}, shifted[15:0]};
                3'b101:  rdata = {16'b0, shifted[15:0]};
                3'b010:  rdata = shifted;
                default: rdata = 32'b0;
            endcase
        end
    end

    assign match   = (mtime >= mtimecmp);
    assign tick    = en && (presc_cnt == prescale);
    assign wrap    = tick && match && reload_en;
    assign wr_time = (wstb != 4'b0000) && (off == 3'd0 || off == 3'd1);

`ifndef MMIO_TIMER_AUTO_RELOAD_EN
    assign reload_en = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime     <= 64'd0;
            mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow    <= 32'd0;
            prescale  <= '0;
            presc_cnt <= '0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            pending   <= 1'b0;
`ifdef MMIO_TIMER_AUTO_RELOAD_EN
            reload_en <= 1'b0;
`endif
        end else begin
            if (en)
                presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);

            // Software writes to mtime win over a same-cycle tick.
            if (wr_time) begin
                if (off == 3'd0)
                    mtime[31:0] <= merge(mtime[31:0], wstb, wd);
                else
                    mtime[63:32] <= merge(mtime[63:32], wstb, wd);
            end else if (wrap) begin
                mtime <= 64'd0;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end

            if (wstb != 4'b0000) begin
                case (off)
                    3'd2: mtimecmp[31:0]  <= merge(mtimecmp[31:0], wstb, wd);
                    3'd3: mtimecmp[63:32] <= merge(mtimecmp[63:32], wstb, wd);
                    3'd4: begin
                        if (wstb[0]) begin
                            en     <= wd[0];
                            irq_en <= wd[1];
`ifdef MMIO_TIMER_AUTO_RELOAD_EN
                            reload_en <= wd[2];
`endif
                        end
                    end
                    3'd5: begin
                        prescale  <= PRESC_W'(merge(32'(prescale), wstb, wd));
                        presc_cnt <= '0;
                    end
                    default: ;
                endcase
            end

            if (match)
                pending <= 1'b1;
            else if (off == 3'd6 && wstb[0] && wd[0])
                pending <= 1'b0;

            // Latch the upper half on a low-word read for tear-free access.
            if (rd_en && sel && off == 3'd0)
                shadow <= mtime[63:32];
        end
    end

    assign timer_interrupt = pending & irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Scoreboard bench for mmio_timer: driver pushes model expectations per cycle,
// monitor pops and compares rdata (on loads) and timer_interrupt (every cycle).
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam int MLO = 0, MHI = 1, CLO = 2, CHI = 3, CTRL = 4, PRE = 5, STAT = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata, rdata;
    logic [2:0]  mode;
    logic        timer_interrupt;

    always #5 clk = ~clk;

    mmio_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .mem_acc_mode(mode), .wdata(wdata), .rdata(rdata),
        .timer_interrupt(timer_interrupt)
    );

    typedef struct packed {
        logic        chk;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    bad = 0;

    // Reference model: whole-register values, byte-lane arithmetic.
    longint unsigned m_time, m_cmp;
    logic [31:0]     m_shadow;
    int unsigned     m_presc, m_cnt;
    bit              m_en, m_irq, m_rel, m_pend;

    task automatic model_reset();
        m_time = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 0;
        m_presc = 0; m_cnt = 0; m_en = 0; m_irq = 0; m_rel = 0; m_pend = 0;
    endtask

    function automatic int acc_size(input logic [2:0] m);
        case (m)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_word(input int o, input bit for_write);
        case (o)
            0: return m_time[31:0];
            1: return for_write ? m_time[63:32] : m_shadow;
            2: return m_cmp[31:0];
            3: return m_cmp[63:32];
            4: return {29'b0, m_rel, m_irq, m_en};
            5: return m_presc;
            6: return {31'b0, m_pend};
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a,
                                               input logic [2:0] m);
        int n = acc_size(m);
        int lane = int'(a[1:0]);
        logic [31:0] w, v;
        if (!rd || a[31:5] != BASE[31:5] || n == 0 || (lane % n) != 0) return 0;
        w = model_word(int'(a[4:2]), 0);
        v = 0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(lane+i) +: 8];
        if (!m[2] && n < 4 && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_step(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [2:0] m, input logic [31:0] wd);
        bit sel = (a[31:5] == BASE[31:5]);
        int n = acc_size(m);
        int lane = int'(a[1:0]);
        int o = int'(a[4:2]);
        bit match = (m_time >= m_cmp);
        bit tick = m_en && (m_cnt == m_presc);
        longint unsigned n_time = m_time;
        int unsigned n_cnt = m_cnt;
        bit n_pend = m_pend;
        logic [31:0] n_shadow = m_shadow;
        logic [31:0] w;
        bit [3:0] sb = 0;
        if (tick) n_time = (m_rel && match) ? 0 : m_time + 1;
        if (m_en) n_cnt = tick ? 0 : m_cnt + 1;
        if (rd && sel && o == 0) n_shadow = m_time[63:32];
        if (wr && sel && n != 0 && (lane % n) == 0) begin
            w = model_word(o, 1);
            for (int i = 0; i < n; i++) begin
                w[8*(lane+i) +: 8] = wd[8*i +: 8];
                sb[lane+i] = 1'b1;
            end
            case (o)
                0: n_time = {m_time[63:32], w};
                1: n_time = {w, m_time[31:0]};
                2: m_cmp[31:0] = w;
                3: m_cmp[63:32] = w;
                4: begin
                    m_en = w[0]; m_irq = w[1];
`ifdef MMIO_TIMER_AUTO_RELOAD_EN
                    m_rel = w[2];
`endif
                end
                5: begin m_presc = w[15:0]; n_cnt = 0; end
                6: if (sb[0] && w[0]) n_pend = 0;
                default: ;
            endcase
        end
        if (match) n_pend = 1;
        m_time = n_time; m_cnt = n_cnt; m_pend = n_pend; m_shadow = n_shadow;
    endtask

    task automatic cycle(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [2:0] m, input logic [31:0] wd, input string nm,
                         input bit use_c = 0, input logic [31:0] c = 0);
        exp_t e;
        @(negedge clk);
        rd_en = rd; wr_en = wr; addr = a; mode = m; wdata = wd;
        e.chk = rd;
        e.rd  = use_c ? c : model_read(rd, a, m);
        e.irq = m_pend & m_irq;
        q.push_back(e);
        nq.push_back(nm);
        model_step(rd, wr, a, m, wd);
    endtask

    task automatic wr_reg(input int o, input logic [31:0] d);
        cycle(0, 1, BASE + 32'(o*4), 3'b010, d, "wr");
    endtask

    task automatic rd_reg(input int o, input string nm);
        cycle(1, 0, BASE + 32'(o*4), 3'b010, 0, nm);
    endtask

    task automatic rd_const(input logic [31:0] a, input logic [2:0] m,
                            input logic [31:0] c, input string nm);
        cycle(1, 0, a, m, 0, nm, 1, c);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 3'b010, 0, "idle");
    endtask

    task automatic check_now(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Monitor: compares whatever the driver queued for this cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e  = q.pop_front();
                nm = nq.pop_front();
                if (e.chk) begin
                    total++;
                    if (rdata !== e.rd) begin
                        bad++;
                        $display("FAIL %s rdata got=%h want=%h", nm, rdata, e.rd);
                    end
                end
                total++;
                if (timer_interrupt !== e.irq) begin
                    bad++;
                    $display("FAIL %s irq got=%b want=%b", nm, timer_interrupt, e.irq);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic mid_reset();
        @(negedge clk);
        rd_en = 0; wr_en = 0;
        #3 rst = 1'b1;
        #1 check_now("rst_irq", {31'b0, timer_interrupt}, 32'd0);
        rd_en = 1; addr = BASE; mode = 3'b010;
        #1 check_now("rst_mtime", rdata, 32'd0);
        addr = BASE + 32'h10;
        #1 check_now("rst_ctrl", rdata, 32'd0);
        addr = BASE + 32'h08;
        #1 check_now("rst_cmp", rdata, 32'hFFFF_FFFF);
        rd_en = 0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [2:0] modes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        rst = 1'b1; rd_en = 0; wr_en = 0; addr = 0; mode = 3'b010; wdata = 0;
        model_reset();
        #2;
        check_now("reset_rdata", rdata, 32'd0);
        check_now("reset_irq", {31'b0, timer_interrupt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        rd_reg(MLO, "rst_mlo");
        rd_reg(CLO, "rst_clo");

        // Prescale 3: 40 enabled cycles give 10 ticks.
        wr_reg(PRE, 3);
        wr_reg(CTRL, 1);
        idle(40);
        rd_const(BASE, 3'b010, 32'd10, "presc3");
        wr_reg(CTRL, 0);
        wr_reg(MLO, 0);
        wr_reg(PRE, 0);
        wr_reg(CTRL, 1);
        idle(40);
        rd_const(BASE, 3'b010, 32'd40, "presc0");
        rd_reg(MHI, "presc0_hi");

        // Compare interrupt
        wr_reg(CTRL, 0);
        wr_reg(MLO, 0);
        wr_reg(MHI, 0);
        wr_reg(CLO, 32'h20);
        wr_reg(CHI, 0);
        wr_reg(CTRL, 3);
        idle(40);
        wr_reg(STAT, 1);
        idle(2);
        wr_reg(CHI, 1);
        wr_reg(STAT, 1);
        idle(3);
        rd_reg(STAT, "status_clr");
        wr_reg(CHI, 0);
        idle(3);
        mid_reset();
        rd_reg(MLO, "post_rst");
        rd_reg(STAT, "post_rst_st");

        // Sub-word access on MTIMECMP_LO
        cycle(0, 1, BASE + 32'h09, 3'b000, 32'hAB, "sb");
        rd_const(BASE + 32'h08, 3'b010, 32'hFFFF_ABFF, "lw_cmp");
        rd_const(BASE + 32'h09, 3'b000, 32'hFFFF_FFAB, "lb");
        rd_const(BASE + 32'h09, 3'b100, 32'h0000_00AB, "lbu");
        cycle(0, 1, BASE + 32'h09, 3'b001, 32'h1234, "sh_mis");
        rd_const(BASE + 32'h08, 3'b010, 32'hFFFF_ABFF, "lw_cmp2");
        rd_const(BASE + 32'h0A, 3'b001, 32'hFFFF_FFFF, "lh");
        rd_const(BASE + 32'h0A, 3'b101, 32'h0000_FFFF, "lhu");
        rd_const(BASE + 32'h09, 3'b001, 32'h0, "lh_mis");
        rd_const(BASE + 32'h0A, 3'b010, 32'h0, "lw_mis");
        rd_const(BASE + 32'h108, 3'b010, 32'h0, "nosel");

        // Tear-free read across the 32-bit carry
        wr_reg(PRE, 0);
        wr_reg(MLO, 32'hFFFF_FFFE);
        wr_reg(MHI, 0);
        wr_reg(CTRL, 1);
        rd_const(BASE, 3'b010, 32'hFFFF_FFFE, "tear_lo0");
        rd_const(BASE + 4, 3'b010, 32'h0, "tear_hi0");
        rd_const(BASE, 3'b010, 32'h0, "tear_lo1");
        rd_const(BASE + 4, 3'b010, 32'h1, "tear_hi1");
        repeat (3) begin
            rd_reg(MLO, "tear_lo");
            rd_reg(MHI, "tear_hi");
        end

        // Store on a tick cycle wins over the increment
        wr_reg(MLO, 5);
        rd_const(BASE, 3'b010, 32'd5, "collide");
        cycle(0, 1, BASE + 32'h01, 3'b000, 32'h77, "collide_b");
        rd_reg(MLO, "collide_b_rd");

`ifdef MMIO_TIMER_AUTO_RELOAD_EN
        wr_reg(CTRL, 0);
        wr_reg(MLO, 0);
        wr_reg(MHI, 0);
        wr_reg(CLO, 4);
        wr_reg(CHI, 0);
        wr_reg(PRE, 0);
        wr_reg(CTRL, 7);
        repeat (12) rd_reg(MLO, "reload_seq");
        wr_reg(STAT, 1);
        idle(12);
        rd_reg(CTRL, "reload_ctrl");
`else
        wr_reg(CTRL, 7);
        rd_reg(CTRL, "ctrl_bit2");
`endif

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int op = $urandom_range(0, 9);
            int o = $urandom_range(0, 7);
            int ln = $urandom_range(0, 3);
            logic [2:0] m = modes[$urandom_range(0, 4)];
            logic [31:0] a = BASE | 32'(o*4 + ln);
            logic [31:0] d = $urandom;
            if ($urandom_range(0, 15) == 0)
                a = a ^ (32'($urandom_range(1, 255)) << 5);
            if (o == PRE && op >= 6) d = d & 32'h7;
            if (op < 5)      cycle(1, 0, a, m, 0, "rand_rd");
            else if (op < 8) cycle(0, 1, a, m, d, "rand_wr");
            else             idle(1);
        end

        idle(2);
        @(negedge clk);
        #3;
        check_now("queue_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
